// File: rtl/audio_sdram_port_if.sv
// Signal bundle between audio_sdram_port, its two clients and the SDRAM controller.
// slave: the port's own view; master: everything surrounding it.
interface audio_sdram_port_if #(
  parameter int unsigned ADDR_W = 25
) ();
  localparam int unsigned DATA_W = 16;

  logic              ctl_init_done;
  logic              aud_rd;
  logic [ADDR_W-1:0] aud_addr;
  logic              aud_wait;
  logic              aud_ac;
  logic [DATA_W-1:0] aud_data;
  logic              ld_session;
  logic              ld_wr;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ack;
  logic              ctl_req;
  logic              ctl_we;
  logic [ADDR_W-1:0] ctl_addr;
  logic [DATA_W-1:0] ctl_wdata;
  logic              ctl_ready;
  logic              ctl_rvalid;
  logic [DATA_W-1:0] ctl_rdata;
  logic              err_timeout;

  modport slave (
    input  ctl_init_done, aud_rd, aud_addr, ld_session, ld_wr, ld_addr, ld_data,
           ctl_ready, ctl_rvalid, ctl_rdata,
    output aud_wait, aud_ac, aud_data, ld_ack, ctl_req, ctl_we, ctl_addr, ctl_wdata,
           err_timeout
  );

  modport master (
    output ctl_init_done, aud_rd, aud_addr, ld_session, ld_wr, ld_addr, ld_data,
           ctl_ready, ctl_rvalid, ctl_rdata,
    input  aud_wait, aud_ac, aud_data, ld_ack, ctl_req, ctl_we, ctl_addr, ctl_wdata,
           err_timeout
  );
endinterface

// File: rtl/audio_sdram_port.sv
// Arbitrates single-word audio reads (priority) and loader writes onto one SDRAM
// controller request port, with a per-transaction watchdog.
module audio_sdram_port #(
  parameter int unsigned ADDR_W  = 25,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                Clk50,
  input  logic                reset,
  audio_sdram_port_if.slave   sdram_bus
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned WDOG_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_A_REQ  = 3'd1,
    S_A_WAIT = 3'd2,
    S_A_DONE = 3'd3,
    S_L_REQ  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [WDOG_W-1:0]   wdog_q, wdog_d;
  logic                wdog_expired;

  logic                aud_wait_q, aud_wait_d;
  logic                aud_ac_q, aud_ac_d;
  logic [DATA_W-1:0]   aud_data_q, aud_data_d;
  logic                ld_ack_q, ld_ack_d;
  logic                ctl_req_q, ctl_req_d;
  logic                ctl_we_q, ctl_we_d;
  logic [ADDR_W-1:0]   ctl_addr_q, ctl_addr_d;
  logic [DATA_W-1:0]   ctl_wdata_q, ctl_wdata_d;
  logic                err_q, err_d;

  logic                init_c;
  logic                aud_go_c;
  logic                ld_go_c;

  assign init_c       = sdram_bus.ctl_init_done;
  assign aud_go_c     = init_c & sdram_bus.aud_rd;
  assign ld_go_c      = init_c & sdram_bus.ld_wr & ~sdram_bus.aud_rd;
  assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT));

  // State register
  always_ff @(posedge Clk50) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; a controller response always beats a coincident timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (aud_go_c)     state_d = S_A_REQ;
        else if (ld_go_c) state_d = S_L_REQ;
      end
      S_A_REQ: begin
        if (sdram_bus.ctl_ready) state_d = S_A_WAIT;
        else if (wdog_expired)   state_d = S_IDLE;
      end
      S_A_WAIT: begin
        if (sdram_bus.ctl_rvalid) state_d = S_A_DONE;
        else if (wdog_expired)    state_d = S_IDLE;
      end
      S_A_DONE: state_d = S_IDLE;
      S_L_REQ: begin
        if (sdram_bus.ctl_ready || wdog_expired) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    aud_wait_d  = sdram_bus.ld_session | ~init_c | (state_q == S_L_REQ);
    aud_ac_d    = 1'b0;
    aud_data_d  = aud_data_q;
    ld_ack_d    = 1'b0;
    ctl_addr_d  = ctl_addr_q;
    ctl_wdata_d = ctl_wdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (aud_go_c) begin
          ctl_addr_d = sdram_bus.aud_addr;
        end else if (ld_go_c) begin
          ctl_addr_d  = sdram_bus.ld_addr;
          ctl_wdata_d = sdram_bus.ld_data;
        end
      end
      S_A_REQ: begin
        if (!sdram_bus.ctl_ready && wdog_expired) err_d = 1'b1;
      end
      S_A_WAIT: begin
        if (sdram_bus.ctl_rvalid) begin
          aud_data_d = sdram_bus.ctl_rdata;
          aud_ac_d   = 1'b1;
        end else if (wdog_expired) begin
          err_d = 1'b1;
        end
      end
      S_L_REQ: begin
        if (sdram_bus.ctl_ready) ld_ack_d = 1'b1;
        else if (wdog_expired)   err_d    = 1'b1;
      end
      default: ;
    endcase

    // Command strobes track the state being entered so they align with it
    ctl_req_d = (state_d == S_A_REQ) || (state_d == S_L_REQ);
    ctl_we_d  = (state_d == S_L_REQ);

    // Watchdog restarts on every entry into a waiting state
    if (state_d != state_q)
      wdog_d = '0;
    else if ((state_q == S_A_REQ) || (state_q == S_A_WAIT) || (state_q == S_L_REQ))
      wdog_d = wdog_q + WDOG_W'(1);
    else
      wdog_d = '0;
  end

  always_ff @(posedge Clk50) begin
    if (reset) begin
      wdog_q      <= '0;
      aud_wait_q  <= 1'b1;
      aud_ac_q    <= 1'b0;
      aud_data_q  <= '0;
      ld_ack_q    <= 1'b0;
      ctl_req_q   <= 1'b0;
      ctl_we_q    <= 1'b0;
      ctl_addr_q  <= '0;
      ctl_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      wdog_q      <= wdog_d;
      aud_wait_q  <= aud_wait_d;
      aud_ac_q    <= aud_ac_d;
      aud_data_q  <= aud_data_d;
      ld_ack_q    <= ld_ack_d;
      ctl_req_q   <= ctl_req_d;
      ctl_we_q    <= ctl_we_d;
      ctl_addr_q  <= ctl_addr_d;
      ctl_wdata_q <= ctl_wdata_d;
      err_q       <= err_d;
    end
  end

  assign sdram_bus.aud_wait    = aud_wait_q;
  assign sdram_bus.aud_ac      = aud_ac_q;
  assign sdram_bus.aud_data    = aud_data_q;
  assign sdram_bus.ld_ack      = ld_ack_q;
  assign sdram_bus.ctl_req     = ctl_req_q;
  assign sdram_bus.ctl_we      = ctl_we_q;
  assign sdram_bus.ctl_addr    = ctl_addr_q;
  assign sdram_bus.ctl_wdata   = ctl_wdata_q;
  assign sdram_bus.err_timeout = err_q;

endmodule

// File: tb/tb_audio_sdram_port.sv
// Bench for audio_sdram_port: directed scenarios with literal expectations, then
// random traffic, all outputs compared each cycle to a request-tracking model.
module tb_audio_sdram_port;

  localparam int unsigned ADDR_W  = 25;
  localparam int unsigned TIMEOUT = 255;

  logic Clk50 = 1'b0;
  logic reset;
  always #10 Clk50 = ~Clk50;

  audio_sdram_port_if #(.ADDR_W(ADDR_W)) bus ();

  audio_sdram_port #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .Clk50     (Clk50),
    .reset     (reset),
    .sdram_bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: tracks the one outstanding transaction at request level
  bit                m_busy, m_wr, m_dph, m_cool;
  int unsigned       m_age;
  logic              e_wait, e_ac, e_ack, e_req, e_we, e_err;
  logic [15:0]       e_data, e_wdata;
  logic [ADDR_W-1:0] e_addr;

  always @(posedge Clk50) begin : ref_model
    if (reset) begin
      m_busy = 0; m_wr = 0; m_dph = 0; m_cool = 0; m_age = 0;
      e_wait = 1; e_ac = 0; e_ack = 0; e_req = 0; e_we = 0; e_err = 0;
      e_data = '0; e_wdata = '0; e_addr = '0;
    end else begin
      e_wait = bus.ld_session | ~bus.ctl_init_done | (m_busy & m_wr);
      e_ac   = 0;
      e_ack  = 0;
      if (m_cool) begin
        m_cool = 0;
      end else if (!m_busy) begin
        if (bus.ctl_init_done && bus.aud_rd) begin
          m_busy = 1; m_wr = 0; m_dph = 0; m_age = 0;
          e_addr = bus.aud_addr;
        end else if (bus.ctl_init_done && bus.ld_wr) begin
          m_busy = 1; m_wr = 1; m_dph = 0; m_age = 0;
          e_addr = bus.ld_addr; e_wdata = bus.ld_data;
        end
      end else if (m_dph ? bus.ctl_rvalid : bus.ctl_ready) begin
        if (m_wr) begin
          m_busy = 0; e_ack = 1;
        end else if (!m_dph) begin
          m_dph = 1; m_age = 0;
        end else begin
          m_busy = 0; m_cool = 1; e_ac = 1; e_data = bus.ctl_rdata;
        end
      end else if (m_age == TIMEOUT) begin
        m_busy = 0; e_err = 1;
      end else begin
        m_age++;
      end
      e_req = m_busy & ~m_dph;
      e_we  = m_busy & m_wr & ~m_dph;
    end
  end

  always @(negedge Clk50) begin : compare
    if (chk_en) begin
      chk("aud_wait",    bus.aud_wait,    e_wait);
      chk("aud_ac",      bus.aud_ac,      e_ac);
      chk("aud_data",    bus.aud_data,    e_data);
      chk("ld_ack",      bus.ld_ack,      e_ack);
      chk("ctl_req",     bus.ctl_req,     e_req);
      chk("ctl_we",      bus.ctl_we,      e_we);
      chk("ctl_addr",    bus.ctl_addr,    e_addr);
      chk("ctl_wdata",   bus.ctl_wdata,   e_wdata);
      chk("err_timeout", bus.err_timeout, e_err);
    end
  end

  // Environment: controller responder and level-holding requesters
  logic [15:0] mem [16];
  bit          pend;
  logic [3:0]  pend_a;
  int          rv_cnt;
  int          fixed_lat = 3;
  bit          rv_en     = 1'b1;
  int          ready_pct = 100;
  int          stray_pct = 0;
  bit          rand_en   = 1'b0;
  int          cyc = 0, n_ac = 0, n_ack = 0, n_req = 0;

  task automatic tick();
    @(negedge Clk50);
    cyc++;
    if (bus.aud_ac)  n_ac++;
    if (bus.ld_ack)  n_ack++;
    if (bus.ctl_req) n_req++;
    bus.ctl_ready  = 1'b0;
    bus.ctl_rvalid = 1'b0;
    if (pend && rv_en) begin
      rv_cnt--;
      if (rv_cnt <= 0) begin
        bus.ctl_rvalid = 1'b1;
        bus.ctl_rdata  = mem[pend_a];
        pend = 1'b0;
      end
    end else if (!pend && $urandom_range(0, 99) < stray_pct) begin
      bus.ctl_rvalid = 1'b1;
      bus.ctl_rdata  = 16'($urandom);
    end
    if (bus.ctl_req && $urandom_range(0, 99) < ready_pct) begin
      bus.ctl_ready = 1'b1;
      if (bus.ctl_we) begin
        mem[bus.ctl_addr[3:0]] = bus.ctl_wdata;
      end else begin
        pend   = 1'b1;
        pend_a = bus.ctl_addr[3:0];
        rv_cnt = (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 5));
      end
    end
    if (bus.aud_rd && bus.aud_ac) bus.aud_rd = 1'b0;
    else if (rand_en && !bus.aud_rd && $urandom_range(0, 7) == 0) begin
      bus.aud_rd   = 1'b1;
      bus.aud_addr = ADDR_W'($urandom);
    end
    if (bus.ld_wr && bus.ld_ack) bus.ld_wr = 1'b0;
    else if (rand_en && !bus.ld_wr && $urandom_range(0, 5) == 0) begin
      bus.ld_wr   = 1'b1;
      bus.ld_addr = ADDR_W'($urandom);
      bus.ld_data = 16'($urandom);
    end
    if (rand_en && $urandom_range(0, 39) == 0) bus.ld_session = ~bus.ld_session;
    if (rand_en) reset = ($urandom_range(0, 399) == 0);
  endtask

  initial begin : watchdog_guard
    #5_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int          t0, a0, k0, t_ac, t_ack;
    logic        first_we;
    bit          seen_req;
    logic [15:0] wd [4];

    reset = 1'b1;
    bus.ctl_init_done = 0; bus.aud_rd = 0; bus.aud_addr = '0;
    bus.ld_session = 0; bus.ld_wr = 0; bus.ld_addr = '0; bus.ld_data = '0;
    bus.ctl_ready = 0; bus.ctl_rvalid = 0; bus.ctl_rdata = '0;
    for (int i = 0; i < 16; i++) mem[i] = 16'(i * 16'h0101);
    mem[0] = 16'hBEEF;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_aud_wait", bus.aud_wait, 1);
    chk("rst_ctl_req",  bus.ctl_req, 0);
    chk("rst_aud_data", bus.aud_data, 0);
    chk("rst_err",      bus.err_timeout, 0);

    // Uninitialised controller: audio held off
    reset = 1'b0;
    bus.aud_rd = 1'b1; bus.aud_addr = 25'h80000;
    n_req = 0;
    for (int i = 0; i < 10; i++) tick();
    chk("noinit_req_cycles", n_req, 0);
    chk("noinit_aud_wait",   bus.aud_wait, 1);

    // Initialise; read of 0x80000 with immediate ready and 3-cycle data latency
    bus.ctl_init_done = 1'b1;
    t0 = cyc; a0 = n_ac;
    tick();
    chk("init_aud_wait", bus.aud_wait, 0);
    chk("rd_req",        bus.ctl_req, 1);
    chk("rd_addr",       bus.ctl_addr, 32'h80000);
    chk("rd_we",         bus.ctl_we, 0);
    for (int i = 0; i < 20 && !bus.aud_ac; i++) tick();
    chk("rd_latency", cyc - t0, 5);
    chk("rd_data",    bus.aud_data, 16'hBEEF);
    for (int i = 0; i < 6; i++) tick();
    chk("rd_data_held", bus.aud_data, 16'hBEEF);
    chk("rd_ac_once",   n_ac - a0, 1);

    // Collision: read wins, write follows after the read completes
    bus.aud_rd = 1'b1; bus.aud_addr = 25'h00001;
    bus.ld_wr  = 1'b1; bus.ld_addr  = 25'h12342; bus.ld_data = 16'hCAFE;
    t0 = cyc; k0 = n_ack; seen_req = 0; first_we = 1'bx; t_ac = 0; t_ack = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.ctl_req && !seen_req) begin seen_req = 1; first_we = bus.ctl_we; end
      if (bus.aud_ac) t_ac  = cyc - t0;
      if (bus.ld_ack) t_ack = cyc - t0;
    end
    chk("col_first_is_read", first_we, 0);
    chk("col_ac_cycle",      t_ac, 5);
    chk("col_ack_cycle",     t_ack, 8);
    chk("col_ack_once",      n_ack - k0, 1);

    // Loader session: four writes, audio held off throughout
    wd[0] = 16'h1357; wd[1] = 16'h2468; wd[2] = 16'hA5A5; wd[3] = 16'h0FF0;
    bus.ld_session = 1'b1;
    k0 = n_ack;
    tick();
    for (int k = 0; k < 4; k++) begin
      bus.ld_wr = 1'b1; bus.ld_addr = ADDR_W'(k + 4); bus.ld_data = wd[k];
      for (int i = 0; i < 20 && bus.ld_wr; i++) begin
        tick();
        chk("sess_aud_wait", bus.aud_wait, 1);
        if (bus.ctl_req && bus.ctl_we) chk("sess_wdata", bus.ctl_wdata, wd[k]);
      end
    end
    chk("sess_acks", n_ack - k0, 4);
    bus.ld_session = 1'b0;
    tick();
    chk("sess_end_wait", bus.aud_wait, 0);

    // Watchdog: data withheld
    rv_en = 1'b0;
    bus.aud_rd = 1'b1; bus.aud_addr = 25'h00005;
    t0 = cyc; a0 = n_ac;
    for (int i = 0; i < 300 && !bus.err_timeout; i++) tick();
    chk("wd_err_cycle", cyc - t0, 258);
    chk("wd_no_ac",     n_ac - a0, 0);
    tick();
    chk("wd_reissue_req", bus.ctl_req, 1);
    chk("wd_reissue_we",  bus.ctl_we, 0);
    rv_en = 1'b1;
    for (int i = 0; i < 20 && !bus.aud_ac; i++) tick();
    chk("wd_reserved", n_ac - a0, 1);
    chk("wd_sticky",   bus.err_timeout, 1);

    // Reset while waiting for read data; the late data must be discarded
    for (int i = 0; i < 3; i++) tick();
    fixed_lat = 6;
    bus.aud_rd = 1'b1; bus.aud_addr = 25'h00002;
    tick();
    tick();
    reset = 1'b1; bus.aud_rd = 1'b0;
    tick();
    reset = 1'b0;
    chk("mid_rst_wait", bus.aud_wait, 1);
    chk("mid_rst_req",  bus.ctl_req, 0);
    chk("mid_rst_data", bus.aud_data, 0);
    chk("mid_rst_err",  bus.err_timeout, 0);
    chk("mid_rst_addr", bus.ctl_addr, 0);
    a0 = n_ac;
    for (int i = 0; i < 8; i++) tick();
    chk("mid_rst_late_rvalid", n_ac - a0, 0);

    // Random traffic
    fixed_lat = 0; ready_pct = 70; stray_pct = 5; rand_en = 1'b1;
    for (int i = 0; i < 6000; i++) tick();
    rand_en = 1'b0; reset = 1'b0; ready_pct = 100; stray_pct = 0;
    for (int i = 0; i < 1000 && (bus.aud_rd || bus.ld_wr); i++) tick();
    chk("drain_idle", bus.aud_rd | bus.ld_wr, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
